single_cycle_mips_processor: RTL and testbench

Single-cycle 32-bit MIPS-subset CPU: fetch, decode, register read, ALU, memory access and writeback all complete in one clock. It is self-contained, with instruction memory, register file and data memory internal. Benches preload program and data through hierarchical references. It is the top of the processor design.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mips_memory.sv | 21 ++
 rtl/register_file.sv | 26 ++
 rtl/single_cycle_mips_processor.sv | 144 ++++++++++++++
 tb/tb_single_cycle_mips_processor.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, R-type functs,
// ALU operation select and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      reg_dst_rd;
    logic      alu_src_imm;
    logic      mem_write;
    logic      mem_to_reg;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/mips_memory.sv
// 256-word memory with a combinational read and an edge-triggered write;
// used for both instruction memory (write tied off) and data memory.
module mips_memory (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] memory [255:0];

  always_ff @(posedge clk) begin
    if (we) begin
      memory[addr] <= wdata;
    end
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one write port
// committed on the rising edge; register 0 is hardwired to zero.
module register_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regFile [31:0];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regFile[wa] <= wd;
    end
  end

  // Reads see the pre-edge value, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regFile[ra2];

endmodule

// File: rtl/single_cycle_mips_processor.sv
// Single-cycle MIPS-subset CPU: fetch, decode, ALU, memory and writeback
// all resolve combinationally and commit on one rising clock edge.
module single_cycle_mips_processor
  import mips_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] alu_result;
  logic [31:0] read_data;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [31:0] alu_b;
  logic [31:0] wb_data;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wa;
  logic        alu_zero;
  ctrl_t       ctrl;

  assign pc = pc_q;

  mips_memory im (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc_q[9:2]),
    .wdata (32'd0),
    .rdata (instr)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl = '0;
    ctrl.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst_rd = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign alu_b = ctrl.alu_src_imm ? imm : rd2;

  always_comb begin
    alu_result = rd1 + alu_b;
    case (ctrl.alu_ctrl)
      ALU_SUB: alu_result = rd1 - alu_b;
      ALU_AND: alu_result = rd1 & alu_b;
      ALU_OR:  alu_result = rd1 | alu_b;
      ALU_SLT: alu_result = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = rd1 + alu_b;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // Data memory is word-indexed straight from the low address bits.
  mips_memory dm (
    .clk   (clk),
    .we    (ctrl.mem_write & rst),
    .addr  (alu_result[7:0]),
    .wdata (rd2),
    .rdata (read_data)
  );

  assign wa      = ctrl.reg_dst_rd ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? read_data : alu_result;

  register_file rf (
    .clk (clk),
    .we  (ctrl.reg_write & rst),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wa),
    .wd  (wb_data),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump) begin
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (ctrl.branch && alu_zero) begin
      pc_d = pc_plus4 + {imm[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_single_cycle_mips_processor.sv
// Scoreboard bench: a behavioural ISA model predicts each retired instruction;
// a negedge monitor compares pc / alu_result / read_data and end-state arrays.
module tb_single_cycle_mips_processor;

  logic clk;
  logic rst;

  single_cycle_mips_processor dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          alu_chk;
    logic [31:0] alu;
    bit          rd_chk;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_dm [256];
  logic [31:0] m_im [256];
  logic [31:0] m_pc;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Reference ISA step: one instruction, plain arithmetic on arrays.
  task automatic model_step();
    exp_t        e;
    logic [31:0] ins, a, b, sx, addr, nxt;
    int          rs, rt, rd;
    ins  = m_im[m_pc[9:2]];
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    a    = m_rf[rs];
    b    = m_rf[rt];
    sx   = {{16{ins[15]}}, ins[15:0]};
    addr = a + sx;
    nxt  = m_pc + 32'd4;
    e.pc = m_pc; e.alu_chk = 0; e.alu = '0; e.rd_chk = 0; e.rdata = '0;
    case (ins[31:26])
      6'h00: begin
        e.alu_chk = 1;
        case (ins[5:0])
          6'h20:   e.alu = a + b;
          6'h22:   e.alu = a - b;
          6'h24:   e.alu = a & b;
          6'h25:   e.alu = a | b;
          6'h2A:   e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.alu_chk = 0;
        endcase
        if (e.alu_chk && rd != 0) m_rf[rd] = e.alu;
      end
      6'h08: begin
        e.alu_chk = 1; e.alu = addr;
        if (rt != 0) m_rf[rt] = addr;
      end
      6'h23: begin
        e.alu_chk = 1; e.alu = addr;
        e.rd_chk = 1; e.rdata = m_dm[addr[7:0]];
        if (rt != 0) m_rf[rt] = m_dm[addr[7:0]];
      end
      6'h2B: begin
        e.alu_chk = 1; e.alu = addr;
        m_dm[addr[7:0]] = b;
      end
      6'h04: begin
        e.alu_chk = 1; e.alu = a - b;
        if (a == b) nxt = m_pc + 32'd4 + (sx << 2);
      end
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    exp_q.push_back(e);
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow: got pc %h expected no retirement", dut.pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc", dut.pc, mon_e.pc);
        if (mon_e.alu_chk) check("alu_result", dut.alu_result, mon_e.alu);
        if (mon_e.rd_chk)  check("read_data", dut.read_data, mon_e.rdata);
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++)  m_rf[i] = '0;
    for (int i = 0; i < 256; i++) begin m_dm[i] = '0; m_im[i] = '0; end
    m_pc = '0;
  endtask

  task automatic sync_dut();
    m_rf[0] = '0;
    for (int i = 0; i < 32; i++)  dut.rf.regFile[i] = m_rf[i];
    for (int i = 0; i < 256; i++) begin dut.dm.memory[i] = m_dm[i]; dut.im.memory[i] = m_im[i]; end
  endtask

  task automatic run_cycles(input int n);
    rst = 1'b1;
    repeat (n) begin
      model_step();
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    m_pc = '0;
  endtask

  task automatic compare_state(input string tag);
    int rf_i = -1;
    int dm_i = -1;
    for (int i = 0; i < 32; i++)  if (rf_i < 0 && dut.rf.regFile[i] !== m_rf[i]) rf_i = i;
    for (int i = 0; i < 256; i++) if (dm_i < 0 && dut.dm.memory[i] !== m_dm[i]) dm_i = i;
    total++;
    if (rf_i >= 0) begin
      bad++;
      $display("FAIL %s_rf: reg %0d got %h expected %h", tag, rf_i, dut.rf.regFile[rf_i], m_rf[rf_i]);
    end
    total++;
    if (dm_i >= 0) begin
      bad++;
      $display("FAIL %s_dm: word %0d got %h expected %h", tag, dm_i, dut.dm.memory[dm_i], m_dm[dm_i]);
    end
    check({tag, "_pc"}, dut.pc, m_pc);
  endtask

  task automatic load_prog1();
    clear_model();
    m_rf[8] = 12; m_rf[9] = 20; m_rf[10] = 30; m_rf[11] = 42;
    m_dm[12] = 100;
    m_im[0] = enc_r(8, 10, 9, 6'h20);
    m_im[1] = enc_r(9, 8, 12, 6'h22);
    m_im[2] = enc_i(6'h23, 8, 10, 0);
    m_im[3] = enc_i(6'h2B, 8, 11, 4);
    m_im[4] = enc_i(6'h04, 11, 9, 1);
    m_im[5] = enc_r(8, 8, 13, 6'h20);
    m_im[6] = enc_i(6'h2B, 8, 12, 8);
    sync_dut();
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd, k;
    rs = int'($urandom_range(0, 15));
    rt = int'($urandom_range(0, 15));
    rd = int'($urandom_range(0, 15));
    k  = int'($urandom_range(0, 12));
    case (k)
      0:  return enc_r(rs, rt, rd, 6'h20);
      1:  return enc_r(rs, rt, rd, 6'h22);
      2:  return enc_r(rs, rt, rd, 6'h24);
      3:  return enc_r(rs, rt, rd, 6'h25);
      4:  return enc_r(rs, rt, rd, 6'h2A);
      5:  return enc_i(6'h08, rs, rt, int'($urandom_range(0, 16)) - 8);
      6:  return enc_i(6'h23, rs, rt, int'($urandom_range(0, 255)));
      7:  return enc_i(6'h2B, rs, rt, int'($urandom_range(0, 255)));
      8:  return enc_i(6'h04, rs, rt, int'($urandom_range(1, 3)));
      9:  return enc_i(6'h04, rs, rt, -int'($urandom_range(2, 3)));
      10: return {6'h02, 26'($urandom_range(0, 255))};
      11: return enc_r(rs, rt, rd, 6'h00);
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: pc held at 0, preloaded contents survive.
    load_prog1();
    @(posedge clk); #1;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_keeps_dm", dut.dm.memory[12], 32'd100);
    mon_en = 1;

    run_cycles(7);
    check("p1_t1", dut.rf.regFile[9], 32'd42);
    check("p1_t4", dut.rf.regFile[12], 32'd30);
    check("p1_t2", dut.rf.regFile[10], 32'd100);
    check("p1_t5_skipped", dut.rf.regFile[13], 32'd0);
    check("p1_dm16", dut.dm.memory[16], 32'd42);
    check("p1_dm20", dut.dm.memory[20], 32'd30);
    check("p1_pc", dut.pc, 32'd32);
    compare_state("p1");
    do_reset();

    // beq not taken, $0 write, unknown opcode, zero word, addi -4, slt, j.
    clear_model();
    m_rf[8] = 12; m_rf[9] = 2; m_rf[11] = 1; m_rf[14] = 32'hFFFF_FFFF; m_rf[15] = 1;
    m_im[0]  = enc_i(6'h04, 11, 9, 3);
    m_im[1]  = enc_r(8, 8, 0, 6'h20);
    m_im[2]  = {6'h3F, 26'h0123456};
    m_im[3]  = 32'h0;
    m_im[4]  = enc_i(6'h08, 8, 8, -4);
    m_im[5]  = enc_r(14, 15, 13, 6'h2A);
    m_im[6]  = {6'h02, 26'h10};
    m_im[16] = enc_r(8, 8, 10, 6'h20);
    sync_dut();
    run_cycles(8);
    check("p2_zero_reg", dut.rf.regFile[0], 32'd0);
    check("p2_addi_neg", dut.rf.regFile[8], 32'd8);
    check("p2_slt_signed", dut.rf.regFile[13], 32'd1);
    check("p2_after_jump", dut.rf.regFile[10], 32'd16);
    check("p2_pc", dut.pc, 32'd68);
    compare_state("p2");
    do_reset();

    // Reset mid-program: sw at im[3] is abandoned, restart from im[0].
    load_prog1();
    run_cycles(3);
    do_reset();
    check("midreset_pc", dut.pc, 32'd0);
    check("midreset_dm16", dut.dm.memory[16], 32'd0);
    compare_state("midreset");
    run_cycles(7);
    compare_state("resume");
    do_reset();

    for (int p = 0; p < 5; p++) begin
      clear_model();
      for (int i = 1; i < 32; i++)
        m_rf[i] = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 3)) - 32'd1) : 32'($urandom);
      for (int i = 0; i < 256; i++) begin
        m_dm[i] = 32'($urandom);
        m_im[i] = rand_instr();
      end
      sync_dut();
      run_cycles(150);
      compare_state("random");
      do_reset();
    end

    mon_en = 0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
